// File: rtl/tug_input_conditioner.sv
// Tug-of-war key conditioner: per-player synchronizer, debounce FSM and press-edge pulse.
// L/R fire once per accepted press (gated by enable); l_held/r_held give the debounced level.

module tug_key_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    input  logic enable,
    output logic pulse,
    output logic held
);
    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic            RELEASED = KEY_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          sync1, sync2;
    logic          key_s;
    logic          press;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign key_s = sync2 ^ KEY_ACTIVE_LOW;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        press    = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) begin
                    // A single required sample completes the debounce on entry.
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                        press    = 1'b1;
                    end else begin
                        state_nx = DEB_PRESS;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            DEB_PRESS: begin
                if (!key_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                    press    = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!key_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = DEB_RELEASE;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            DEB_RELEASE: begin
                if (key_s) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pulse <= press & enable;
        end
    end

    assign held = (state == HELD) || (state == DEB_RELEASE);
endmodule

module tug_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_raw,
    input  logic key_r_raw,
    input  logic enable,
    output logic L,
    output logic R,
    output logic l_held,
    output logic r_held
);
    tug_key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_left (
        .clk    (clk),
        .reset  (reset),
        .key_raw(key_l_raw),
        .enable (enable),
        .pulse  (L),
        .held   (l_held)
    );

    tug_key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_right (
        .clk    (clk),
        .reset  (reset),
        .key_raw(key_r_raw),
        .enable (enable),
        .pulse  (R),
        .held   (r_held)
    );
endmodule

// File: tb/tb_tug_input_conditioner.sv
// Bench for tug_input_conditioner: directed plan steps plus random key traffic, checked against
// a history-window model (accepted level flips after D consecutive opposite synchronized samples).

module tb_tug_input_conditioner;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic reset, key_l_raw, key_r_raw, enable;
    logic L, R, l_held, r_held;

    int checks = 0;
    int errors = 0;
    int cnt_l, cnt_r, cnt_both;

    // model state, index 0 = left, 1 = right
    bit          s1 [2];
    bit          s2 [2];
    logic [63:0] h  [2];
    int          n  [2];
    bit          lvl[2];
    bit          pls[2];

    always #5 clk = ~clk;

    tug_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_l_raw(key_l_raw),
        .key_r_raw(key_r_raw),
        .enable   (enable),
        .L        (L),
        .R        (R),
        .l_held   (l_held),
        .r_held   (r_held)
    );

    task automatic model_edge(input bit l, input bit r, input bit e, input bit rn);
        bit p[2];
        bit ks;
        bit all_opp;
        p[0] = l;
        p[1] = r;
        for (int c = 0; c < 2; c++) begin
            if (!rn) begin
                s1[c] = 1'b0; s2[c] = 1'b0; h[c] = '0; n[c] = 0;
                lvl[c] = 1'b0; pls[c] = 1'b0;
            end else begin
                ks    = s2[c];
                s2[c] = s1[c];
                s1[c] = p[c];
                h[c]  = {h[c][62:0], ks};
                n[c]  = n[c] + 1;
                all_opp = (n[c] >= int'(D));
                for (int i = 0; i < int'(D); i++)
                    if (h[c][i] == lvl[c]) all_opp = 1'b0;
                pls[c] = all_opp && !lvl[c] && e;
                if (all_opp) lvl[c] = !lvl[c];
            end
        end
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0b expected %0b at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_cnt(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // l/r are "pressed" levels; the raw keys are active-low
    task automatic step(input bit l, input bit r, input bit e, input bit rn);
        reset     = rn;
        key_l_raw = ~l;
        key_r_raw = ~r;
        enable    = e;
        @(posedge clk);
        model_edge(l, r, e, rn);
        #1;
        chk("L", L, pls[0]);
        chk("R", R, pls[1]);
        chk("l_held", l_held, lvl[0]);
        chk("r_held", r_held, lvl[1]);
        cnt_l    += int'(L);
        cnt_r    += int'(R);
        cnt_both += int'(L & R);
    endtask

    task automatic clr_counts();
        cnt_l = 0; cnt_r = 0; cnt_both = 0;
    endtask

    initial begin
        bit pl, pr, en, rn;
        clr_counts();

        // reset and idle
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
        chk_cnt("idle_pulses", cnt_l + cnt_r, 0);

        // clean left press
        clr_counts();
        for (int i = 0; i < 20; i++) step(1, 0, 1, 1);
        chk_cnt("clean_L", cnt_l, 1);
        chk_cnt("clean_R", cnt_r, 0);
        chk("clean_held", l_held, 1'b1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1);

        // right bounce on press, then hold
        clr_counts();
        for (int i = 0; i < 8; i++) step(0, (i % 2) == 0, 1, 1);
        for (int i = 0; i < 15; i++) step(0, 1, 1, 1);
        chk_cnt("bounce_press_R", cnt_r, 1);
        // bounce on release
        clr_counts();
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1);
        chk_cnt("bounce_release_R", cnt_r, 0);
        chk("released_r_held", r_held, 1'b0);

        // simultaneous presses, twice
        clr_counts();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 12; i++) step(1, 1, 1, 1);
            for (int i = 0; i < 12; i++) step(0, 0, 1, 1);
        end
        chk_cnt("simul_L", cnt_l, 2);
        chk_cnt("simul_R", cnt_r, 2);
        chk_cnt("simul_both", cnt_both, 2);

        // enable gating
        clr_counts();
        for (int i = 0; i < 12; i++) step(1, 0, 0, 1);
        chk("gated_held", l_held, 1'b1);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 1);
        chk_cnt("gated_L", cnt_l, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
        for (int i = 0; i < 12; i++) step(1, 0, 1, 1);
        chk_cnt("regate_L", cnt_l, 1);

        // reset while held
        step(1, 0, 1, 0);
        chk("rst_l_held", l_held, 1'b0);
        clr_counts();
        for (int i = 0; i < 12; i++) step(1, 0, 1, 1);
        chk_cnt("post_reset_L", cnt_l, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1);

        // random traffic
        pl = 1'b0; pr = 1'b0; en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) pl = !pl;
            if ($urandom_range(0, 4) == 0) pr = !pr;
            if ($urandom_range(0, 19) == 0) en = !en;
            rn = ($urandom_range(0, 99) != 0);
            step(pl, pr, en, rn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
